vector_fpu_sequencer: RTL and testbench
=======================================

# vector_fpu_sequencer

Issue stage directly upstream of the scalar FPU in the vector datapath: accepts one vector instruction (opcode plus LANES packed single-precision operand pairs), issues the lanes one at a time to the FPU's enable/ready handshake, and collects the lane results into a packed result vector. It owns FPU sequencing: it drops the FPU enable between lanes so the FPU restarts its internal counter, and it watches each lane with a timeout.

## Interface
- LANES, 4, number of vector elements per instruction (≥1)
- TIMEOUT, 64, max cycles a lane waits for fpu_ready before abort (≥20)
- CLK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- opcode  in  2  00 ADD, 01 SUB, 10 DIV, 11 MUL; latched on start
- vec_a  in  32*LANES  operand A, lane i at [32i+31:32i]; latched on start
- vec_b  in  32*LANES  operand B, same packing; latched on start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, instruction finished (normal or abort)
- error  out  1  sticky timeout flag, cleared on next accepted start
- result  out  32*LANES  packed results, valid when done=1, held until next capture
- fpu_enable  out  1  FPU enable (registered)
- fpu_A, fpu_B  out  32  current lane operands (registered)
- fpu_opcode  out  2  latched opcode
- fpu_ready  in  1  FPU result ready
- fpu_O  in  32  FPU result

## Operation
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE: start=1 latches opcode/vec_a/vec_b, lane index ← 0, error ← 0, → ISSUE. start while not IDLE ignored.
- ISSUE (1 cycle): fpu_A/fpu_B = lane[idx], fpu_enable=1, timeout counter ← 0, → WAIT.
- WAIT: fpu_enable stays 1, operands stable. fpu_ready=1 at a clock edge: result lane[idx] ← fpu_O, → GAP. Else counter+1; when counter reaches TIMEOUT: error ← 1, lanes idx..LANES-1 ← 32'h7FC00000 (qNaN), → GAP with abort flag set.
- GAP (1 cycle): fpu_enable=0 (FPU clears counter). If abort or idx=LANES-1 → DONE; else idx+1, → ISSUE.
- DONE (1 cycle): done=1, → IDLE.
- fpu_opcode constant for whole instruction; sequencer does no arithmetic, FPU handles special values.
- Lane index width clog2(LANES) (min 1); timeout counter width clog2(TIMEOUT+1).

## Timing
- Reset values: busy 0, done 0, error 0, result 0, fpu_enable 0, fpu_A 0, fpu_B 0, fpu_opcode 0, state IDLE.
- Reset mid-instruction: immediate return to reset values, fpu_enable drops asynchronously; partial results discarded.
- Start sampled at edge ending cycle s: ISSUE lane 0 (fpu_enable high) in s+1.
- FPU ready latency L = cycles from first fpu_enable-high cycle to first fpu_ready-high cycle (FPU: ADD/SUB/MUL small, DIV ≥16). Per lane: L+2 cycles (enable-high cycles L+1 incl. capture, plus 1 GAP).
- done asserted in cycle s+1+LANES*(L+2); busy high s+1 through that cycle; next start accepted from the following cycle (IDLE).
- fpu_ready high in the ISSUE cycle itself is ignored (stale); only sampled in WAIT.
- fpu_enable low for exactly 1 cycle between lanes; never low during WAIT.
- Timeout abort: done in cycle (ISSUE cycle)+TIMEOUT+3.

## Test plan
- Reset: assert reset mid-WAIT on lane 2 -> all outputs at reset values same cycle, fpu_enable 0; after release, new start completes normally.
- ADD, LANES=4, bench FPU model L=2: A lanes {1.0,2.0,3.0,4.0} (3F800000,40000000,40400000,40800000), B all 1.0 -> done at s+17, result {40000000,40400000,40800000,40A00000}, error 0.
- DIV with model L=17: A=6.0 (40C00000) all lanes, B=2.0 (40000000) -> each lane enable-high 18 cycles, fpu_enable low 1 cycle between lanes, done at s+77, result all 40400000.
- Start pulsed during busy with different opcode/operands -> ignored, fpu_opcode and results unchanged, single done pulse.
- Timeout: model never raises ready on lane 1, TIMEOUT=64 -> error 1, lane 0 holds its result, lanes 1-3 = 7FC00000, done one pulse; next start clears error.
- Back-to-back: start held high continuously with L=2 -> second instruction's ISSUE exactly 2 cycles after first done (IDLE accept then ISSUE), no overlap of fpu_enable.

Source files
------------

// File: rtl/vector_fpu_sequencer.sv
// Vector FPU issue sequencer: feeds LANES operand pairs to a scalar FPU
// one lane at a time and gathers the lane results into a packed vector.
module vector_fpu_sequencer #(
   parameter int LANES   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            opcode,
   input  logic [32*LANES-1:0]   vec_a,
   input  logic [32*LANES-1:0]   vec_b,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [32*LANES-1:0]   result,
   output logic                  fpu_enable,
   output logic [31:0]           fpu_A,
   output logic [31:0]           fpu_B,
   output logic [1:0]            fpu_opcode,
   input  logic                  fpu_ready,
   input  logic [31:0]           fpu_O
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [31:0]   QNAN = 32'h7FC0_0000;
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [LANES-1:0][31:0] op_a;
   logic [LANES-1:0][31:0] op_b;
   logic [LANES-1:0][31:0] res;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          idx_nx;
   logic [CW-1:0]          cnt;
   logic                   abort;
   logic                   last;
   logic                   expire;

   assign last   = (idx == LAST);
   assign expire = (cnt == TMAX);
   assign idx_nx = idx + IW'(1);
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign result = res;

   // Next-state selection for the lane issue sequence
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (fpu_ready || expire) state_nx = GAP;
         GAP:     state_nx = (abort || last) ? DONE : ISSUE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Operand latching, FPU drive, timeout count and result capture
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         op_a       <= '0;
         op_b       <= '0;
         res        <= '0;
         idx        <= '0;
         cnt        <= '0;
         abort      <= 1'b0;
         error      <= 1'b0;
         fpu_enable <= 1'b0;
         fpu_A      <= '0;
         fpu_B      <= '0;
         fpu_opcode <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a       <= vec_a;
                  op_b       <= vec_b;
                  fpu_opcode <= opcode;
                  idx        <= '0;
                  error      <= 1'b0;
                  abort      <= 1'b0;
                  fpu_enable <= 1'b1;
                  fpu_A      <= vec_a[31:0];
                  fpu_B      <= vec_b[31:0];
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               if (fpu_ready) begin
                  res[idx]   <= fpu_O;
                  fpu_enable <= 1'b0;
               end else if (expire) begin
                  error      <= 1'b1;
                  abort      <= 1'b1;
                  fpu_enable <= 1'b0;
                  for (int i = 0; i < LANES; i++)
                     if (IW'(i) >= idx) res[i] <= QNAN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               if (!(abort || last)) begin
                  idx        <= idx_nx;
                  fpu_enable <= 1'b1;
                  fpu_A      <= op_a[idx_nx];
                  fpu_B      <= op_b[idx_nx];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_fpu_sequencer.sv
// Bench for vector_fpu_sequencer: behavioural FPU stub with programmable
// latency, plus a lane-level reference for results and completion timing.
module tb_vector_fpu_sequencer;

   localparam int LANES   = 4;
   localparam int TIMEOUT = 64;
   localparam int VW      = 32 * LANES;

   logic          CLK = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    opcode;
   logic [VW-1:0] vec_a;
   logic [VW-1:0] vec_b;
   logic          busy;
   logic          done;
   logic          error;
   logic [VW-1:0] result;
   logic          fpu_enable;
   logic [31:0]   fpu_A;
   logic [31:0]   fpu_B;
   logic [1:0]    fpu_opcode;
   logic          fpu_ready;
   logic [31:0]   fpu_O;

   vector_fpu_sequencer #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .reset(reset), .start(start), .opcode(opcode),
      .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .done(done),
      .error(error), .result(result), .fpu_enable(fpu_enable),
      .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_opcode(fpu_opcode),
      .fpu_ready(fpu_ready), .fpu_O(fpu_O)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // float helpers for the FPU stub (operands kept in a safe exponent range)
   function automatic real f2r(input logic [31:0] x);
      real r;
      int  e;
      e = int'(x[30:23]);
      if (e == 0) return 0.0;
      r = 1.0 + $itor({9'd0, x[22:0]}) / 8388608.0;
      while (e > 127) begin r = r * 2.0; e--; end
      while (e < 127) begin r = r / 2.0; e++; end
      return x[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      logic s;
      int   e;
      int   m;
      real  a;
      s = (v < 0.0);
      a = s ? -v : v;
      if (a == 0.0) return 32'h0;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      m = $rtoi((a - 1.0) * 8388608.0);
      return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fp_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         2'b00:   return r2f(f2r(a) + f2r(b));
         2'b01:   return r2f(f2r(a) - f2r(b));
         2'b10:   return r2f(f2r(a) / f2r(b));
         default: return r2f(f2r(a) * f2r(b));
      endcase
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // FPU stub: ready L cycles after enable rises; optional stale ready in
   // the first enable cycle (with garbage data); optional hang on one operand
   int          lat = 2;
   bit          stale = 1'b0;
   bit          hang = 1'b0;
   logic [31:0] hang_a = 32'h0;
   int          fcnt;

   always @(posedge CLK or posedge reset)
      if (reset)            fcnt <= 0;
      else if (!fpu_enable) fcnt <= 0;
      else                  fcnt <= fcnt + 1;

   assign fpu_ready = fpu_enable && !(hang && fpu_A == hang_a) &&
                      (fcnt >= lat || (stale && fcnt == 0));
   assign fpu_O = (fcnt >= lat) ? fp_op(fpu_opcode, fpu_A, fpu_B)
                                : 32'hDEAD_BEEF;

   // enable run-length observer
   int hi_runs[$];
   int lo_runs[$];
   int hi_len;
   int lo_len;
   bit seen_hi;

   always @(negedge CLK) begin
      if (fpu_enable) begin
         if (seen_hi && lo_len > 0) lo_runs.push_back(lo_len);
         lo_len = 0;
         hi_len++;
         seen_hi = 1'b1;
      end else begin
         if (hi_len > 0) hi_runs.push_back(hi_len);
         hi_len = 0;
         if (busy && seen_hi) lo_len++;
      end
   end

   task automatic mon_clear();
      hi_runs.delete();
      lo_runs.delete();
      hi_len  = 0;
      lo_len  = 0;
      seen_hi = 1'b0;
   endtask

   // lane-level reference: lanes from hang_lane upward read as qNaN
   function automatic logic [VW-1:0] ref_vec(input logic [1:0] op,
                                             input logic [VW-1:0] a,
                                             input logic [VW-1:0] b,
                                             input int hang_lane);
      logic [VW-1:0] r;
      for (int i = 0; i < LANES; i++)
         r[32*i +: 32] = (i >= hang_lane) ? 32'h7FC0_0000
                                          : fp_op(op, a[32*i +: 32], b[32*i +: 32]);
      return r;
   endfunction

   function automatic int ref_done(input int s, input int l, input int hang_lane);
      if (hang_lane < LANES) return s + 1 + hang_lane * (l + 2) + TIMEOUT + 3;
      return s + 1 + LANES * (l + 2);
   endfunction

   task automatic start_instr(input logic [1:0] op, input logic [VW-1:0] a,
                              input logic [VW-1:0] b, output int s);
      @(negedge CLK);
      opcode = op;
      vec_a  = a;
      vec_b  = b;
      start  = 1'b1;
      s      = cyc;
      mon_clear();
      @(negedge CLK);
      start  = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dc);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      n_vec++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL done_wait: done=%b after %0d cycles, want 1", done, budget);
      end
      dc = cyc;
   endtask

   task automatic test_reset();
      int s;
      int dc;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      n_vec++;
      if ({busy, done, error, fpu_enable, fpu_opcode, fpu_A, fpu_B, result} !== '0) begin
         n_bad++;
         $display("FAIL reset_init: busy=%b done=%b err=%b en=%b op=%h A=%h B=%h res=%h, want all 0",
                  busy, done, error, fpu_enable, fpu_opcode, fpu_A, fpu_B, result);
      end
      @(negedge CLK);
      reset = 1'b0;
      lat = 2;
      for (int i = 0; i < LANES; i++) begin
         a[32*i +: 32] = rnd_f();
         b[32*i +: 32] = rnd_f();
      end
      start_instr(2'b11, a, b, s);
      while (cyc < s + 10) @(negedge CLK);
      n_vec++;
      if (fpu_enable !== 1'b1 || fpu_A !== a[95:64]) begin
         n_bad++;
         $display("FAIL reset_lane2: en=%b A=%h, want 1 %h", fpu_enable, fpu_A, a[95:64]);
      end
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if ({busy, done, error, fpu_enable, fpu_opcode, fpu_A, fpu_B, result} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: busy=%b done=%b err=%b en=%b op=%h A=%h B=%h res=%h, want all 0",
                  busy, done, error, fpu_enable, fpu_opcode, fpu_A, fpu_B, result);
      end
      @(negedge CLK);
      reset = 1'b0;
      start_instr(2'b01, a, b, s);
      wait_done(200, dc);
      n_vec++;
      if (dc !== ref_done(s, 2, LANES) || result !== ref_vec(2'b01, a, b, LANES)) begin
         n_bad++;
         $display("FAIL reset_rerun: done@%0d res=%h, want done@%0d res=%h",
                  dc, result, ref_done(s, 2, LANES), ref_vec(2'b01, a, b, LANES));
      end
   endtask

   task automatic test_add();
      int s;
      int dc;
      bit ok;
      lat = 2;
      start_instr(2'b00, 128'h40800000_40400000_40000000_3F800000,
                  {4{32'h3F800000}}, s);
      n_vec++;
      if (busy !== 1'b1 || fpu_enable !== 1'b1 || fpu_A !== 32'h3F800000) begin
         n_bad++;
         $display("FAIL add_issue: busy=%b en=%b A=%h, want 1 1 3f800000", busy, fpu_enable, fpu_A);
      end
      wait_done(200, dc);
      n_vec++;
      if (dc - s !== 17) begin
         n_bad++;
         $display("FAIL add_latency: done at s+%0d, want s+17", dc - s);
      end
      n_vec++;
      if (result !== 128'h40A00000_40800000_40400000_40000000 || error !== 1'b0) begin
         n_bad++;
         $display("FAIL add_result: res=%h err=%b, want 40a00000408000004040000040000000 0",
                  result, error);
      end
      ok = (hi_runs.size() == LANES) && (lo_runs.size() == LANES - 1);
      foreach (hi_runs[i]) if (hi_runs[i] != 3) ok = 1'b0;
      foreach (lo_runs[i]) if (lo_runs[i] != 1) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL add_enable_runs: hi=%p lo=%p, want 4x3 and 3x1", hi_runs, lo_runs);
      end
      @(negedge CLK);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL add_after_done: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_div();
      int s;
      int dc;
      bit ok;
      lat = 17;
      start_instr(2'b10, {4{32'h40C00000}}, {4{32'h40000000}}, s);
      wait_done(400, dc);
      n_vec++;
      if (dc - s !== 77 || result !== {4{32'h40400000}}) begin
         n_bad++;
         $display("FAIL div: done at s+%0d res=%h, want s+77 %h", dc - s, result, {4{32'h40400000}});
      end
      ok = (hi_runs.size() == LANES) && (lo_runs.size() == LANES - 1);
      foreach (hi_runs[i]) if (hi_runs[i] != 18) ok = 1'b0;
      foreach (lo_runs[i]) if (lo_runs[i] != 1) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL div_enable_runs: hi=%p lo=%p, want 4x18 and 3x1", hi_runs, lo_runs);
      end
   endtask

   task automatic test_ignore_start();
      int s;
      int dc;
      int extra = 0;
      bit op_ok = 1'b1;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      lat = 3;
      for (int i = 0; i < LANES; i++) begin
         a[32*i +: 32] = rnd_f();
         b[32*i +: 32] = rnd_f();
      end
      start_instr(2'b01, a, b, s);
      for (int k = 0; k < 10; k++) begin
         opcode = 2'(k);
         vec_a  = {4{rnd_f()}};
         vec_b  = {4{rnd_f()}};
         start  = 1'b1;
         @(negedge CLK);
         if (fpu_opcode !== 2'b01) op_ok = 1'b0;
      end
      start = 1'b0;
      n_vec++;
      if (!op_ok) begin
         n_bad++;
         $display("FAIL ignore_opcode: fpu_opcode=%h, want 1", fpu_opcode);
      end
      wait_done(200, dc);
      n_vec++;
      if (dc !== ref_done(s, 3, LANES) || result !== ref_vec(2'b01, a, b, LANES)) begin
         n_bad++;
         $display("FAIL ignore_result: done@%0d res=%h, want done@%0d res=%h",
                  dc, result, ref_done(s, 3, LANES), ref_vec(2'b01, a, b, LANES));
      end
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_vec++;
      if (extra !== 0) begin
         n_bad++;
         $display("FAIL ignore_single_done: %0d busy/done cycles after done, want 0", extra);
      end
   endtask

   task automatic test_timeout();
      int s;
      int dc;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      lat    = 2;
      a      = 128'h40800000_40400000_40A00000_3F800000;
      b      = {4{32'h3F800000}};
      hang_a = 32'h40A00000;
      hang   = 1'b1;
      start_instr(2'b00, a, b, s);
      wait_done(300, dc);
      n_vec++;
      if (dc !== ref_done(s, 2, 1) || error !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_done: done@%0d err=%b, want done@%0d err=1",
                  dc, error, ref_done(s, 2, 1));
      end
      n_vec++;
      if (result !== 128'h7FC00000_7FC00000_7FC00000_40000000) begin
         n_bad++;
         $display("FAIL timeout_result: res=%h, want 7fc000007fc000007fc0000040000000", result);
      end
      @(negedge CLK);
      n_vec++;
      if (done !== 1'b0 || error !== 1'b1 || fpu_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_after: done=%b err=%b en=%b, want 0 1 0", done, error, fpu_enable);
      end
      hang = 1'b0;
      start_instr(2'b11, a, b, s);
      n_vec++;
      if (error !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_clear: err=%b, want 0", error);
      end
      wait_done(200, dc);
      n_vec++;
      if (dc !== ref_done(s, 2, LANES) || result !== ref_vec(2'b11, a, b, LANES) || error !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_rerun: done@%0d res=%h err=%b, want done@%0d res=%h err=0",
                  dc, result, error, ref_done(s, 2, LANES), ref_vec(2'b11, a, b, LANES));
      end
   endtask

   task automatic test_back_to_back();
      int s;
      int dc1;
      int dc2;
      logic [VW-1:0] a2;
      logic [VW-1:0] b2;
      lat = 2;
      @(negedge CLK);
      opcode = 2'b00;
      vec_a  = {4{32'h3F800000}};
      vec_b  = {4{32'h3F800000}};
      start  = 1'b1;
      s      = cyc;
      mon_clear();
      @(negedge CLK);
      wait_done(200, dc1);
      n_vec++;
      if (dc1 - s !== 17 || result !== {4{32'h40000000}}) begin
         n_bad++;
         $display("FAIL b2b_first: done at s+%0d res=%h, want s+17 %h", dc1 - s, result, {4{32'h40000000}});
      end
      for (int i = 0; i < LANES; i++) begin
         a2[32*i +: 32] = rnd_f();
         b2[32*i +: 32] = rnd_f();
      end
      opcode = 2'b10;
      vec_a  = a2;
      vec_b  = b2;
      @(negedge CLK);
      n_vec++;
      if (fpu_enable !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: en=%b busy=%b at done+1, want 0 0", fpu_enable, busy);
      end
      @(negedge CLK);
      start = 1'b0;
      n_vec++;
      if (fpu_enable !== 1'b1 || busy !== 1'b1 || fpu_A !== a2[31:0]) begin
         n_bad++;
         $display("FAIL b2b_issue: en=%b busy=%b A=%h at done+2, want 1 1 %h",
                  fpu_enable, busy, fpu_A, a2[31:0]);
      end
      wait_done(200, dc2);
      n_vec++;
      if (dc2 - dc1 !== 18 || result !== ref_vec(2'b10, a2, b2, LANES)) begin
         n_bad++;
         $display("FAIL b2b_second: done at first+%0d res=%h, want first+18 %h",
                  dc2 - dc1, result, ref_vec(2'b10, a2, b2, LANES));
      end
   endtask

   task automatic test_random();
      int s;
      int dc;
      logic [1:0] op;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      for (int n = 0; n < 12; n++) begin
         op    = 2'($urandom);
         lat   = int'($urandom_range(1, 20));
         stale = 1'($urandom);
         for (int i = 0; i < LANES; i++) begin
            a[32*i +: 32] = rnd_f();
            b[32*i +: 32] = rnd_f();
         end
         start_instr(op, a, b, s);
         wait_done(400, dc);
         n_vec++;
         if (dc !== ref_done(s, lat, LANES)) begin
            n_bad++;
            $display("FAIL rand_timing[%0d]: done@%0d, want %0d (L=%0d)", n, dc, ref_done(s, lat, LANES), lat);
         end
         n_vec++;
         if (result !== ref_vec(op, a, b, LANES) || error !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_result[%0d]: res=%h err=%b, want %h 0", n, result, error, ref_vec(op, a, b, LANES));
         end
      end
      stale = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      opcode = 2'b00;
      vec_a  = '0;
      vec_b  = '0;
      repeat (3) @(negedge CLK);
      test_reset();
      test_add();
      test_div();
      test_ignore_start();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
